// File: rtl/prim_pkg.sv
// Shared helpers for the primitive library: index-width computation used by
// arbiters and their benches.
package prim_pkg;

   // Width of an index able to address n items; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage : prim_pkg

// File: rtl/prim_rr_pick.sv
// Combinational round-robin pick: finds the first set request at or above
// ptr, wrapping to index 0, and returns it one-hot and encoded.
module prim_rr_pick
   import prim_pkg::*;
#(
   parameter int unsigned N    = 4,
   parameter int unsigned IDXW = idx_width(N)
) (
   input  logic [N-1:0]    req,
   input  logic [IDXW-1:0] ptr,
   output logic [N-1:0]    gnt,
   output logic [IDXW-1:0] idx,
   output logic            any
);

   logic [N-1:0]   mask;
   logic [2*N-1:0] dbl;
   logic           found;

   // Double-width search: the lower half holds only requests at or above ptr,
   // the upper half holds all requests, so the first set bit is the winner.
   // NOTE: every output gets a default before the loop, otherwise the
   // "no request" path would infer latches.
   always_comb begin
      mask  = '0;
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         mask[i] = (i >= int'(ptr));
      end
      dbl = {req, req & mask};
      for (int i = 0; i < 2 * N; i++) begin
         if (!found && dbl[i]) begin
            found        = 1'b1;
            gnt[i % N]   = 1'b1;
            idx          = IDXW'(i % N);
         end
      end
      any = found;
   end

endmodule : prim_rr_pick

// File: rtl/prim_rr_arb.sv
// Round-robin arbiter sharing one registered valid/ready output stage among
// N requesters. The most recent winner drops to lowest priority.
module prim_rr_arb
   import prim_pkg::*;
#(
   parameter int unsigned N               = 4,
   parameter int unsigned WIDTH           = 32,
   parameter bit          ZERO_ON_INVALID = 1'b0,
   localparam int unsigned IDXW           = idx_width(N)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [N-1:0]         req_vld_i,
   output logic [N-1:0]         req_rdy_o,
   input  logic [N*WIDTH-1:0]   req_dat_i,
   input  logic                 drdy_i,
   output logic                 dvld_o,
   output logic [WIDTH-1:0]     ddat_o,
   output logic [IDXW-1:0]      didx_o
);

   logic             dvld_q, dvld_d;
   logic [WIDTH-1:0] ddat_q, ddat_d;
   logic [IDXW-1:0]  didx_q, didx_d;
   logic [IDXW-1:0]  ptr_q,  ptr_d;

   logic [N-1:0]     win_gnt;
   logic [IDXW-1:0]  win_idx;
   logic             win_any;
   logic             open;

   prim_rr_pick #(
      .N    (N),
      .IDXW (IDXW)
   ) u_pick (
      .req (req_vld_i),
      .ptr (ptr_q),
      .gnt (win_gnt),
      .idx (win_idx),
      .any (win_any)
   );

   // The output stage can take a beat when it is empty or being drained.
   assign open      = drdy_i | ~dvld_q;
   assign req_rdy_o = open ? win_gnt : '0;

   // Next-state of the output stage and the priority pointer.
   always_comb begin
      dvld_d = dvld_q;
      ddat_d = ddat_q;
      didx_d = didx_q;
      ptr_d  = ptr_q;
      if (open) begin
         if (win_any) begin
            dvld_d = 1'b1;
            ddat_d = req_dat_i[int'(win_idx)*WIDTH +: WIDTH];
            didx_d = win_idx;
            ptr_d  = (win_idx == IDXW'(N - 1)) ? '0 : win_idx + IDXW'(1);
         end else begin
            dvld_d = 1'b0;
            if (ZERO_ON_INVALID) begin
               ddat_d = '0;
            end
         end
      end
   end

   // State registers; reset drops any held beat.
   // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dvld_q <= 1'b0;
         ddat_q <= '0;
         didx_q <= '0;
         ptr_q  <= '0;
      end else begin
         dvld_q <= dvld_d;
         ddat_q <= ddat_d;
         didx_q <= didx_d;
         ptr_q  <= ptr_d;
      end
   end

   assign dvld_o = dvld_q;
   assign ddat_o = ddat_q;
   assign didx_o = didx_q;

endmodule : prim_rr_arb

// File: tb/tb_prim_rr_arb.sv
// Bench for prim_rr_arb: directed scenarios plus a valid/ready stress run,
// with a scoreboard queue filled at handshake time and drained by a monitor
// when the downstream consumes a beat.
module tb_prim_rr_arb;
   import prim_pkg::*;

   localparam int unsigned N    = 4;
   localparam int unsigned W    = 32;
   localparam int unsigned IDXW = idx_width(N);

   typedef struct packed {
      logic [IDXW-1:0] idx;
      logic [W-1:0]    dat;
   } beat_t;

   logic               clk = 1'b0;
   logic               reset_n;
   logic [N-1:0]       req_vld;
   logic [N-1:0]       req_rdy;
   logic [N*W-1:0]     req_dat;
   logic               drdy;
   logic               dvld;
   logic [W-1:0]       ddat;
   logic [IDXW-1:0]    didx;

   int n_checks = 0;
   int n_fail   = 0;

   beat_t sb_q[$];

   // Reference model state
   int          m_ptr;
   bit          m_vld;
   logic [W-1:0] m_dat;
   int          m_idx;
   int          last_win;

   prim_rr_arb #(
      .N               (N),
      .WIDTH           (W),
      .ZERO_ON_INVALID (1'b1)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_vld_i (req_vld),
      .req_rdy_o (req_rdy),
      .req_dat_i (req_dat),
      .drdy_i    (drdy),
      .dvld_o    (dvld),
      .ddat_o    (ddat),
      .didx_o    (didx)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] dat_of(input int k);
      return req_dat[k*W +: W];
   endfunction

   // Drive one cycle: inputs at posedge+1, ready checked, model updated,
   // registered outputs compared at the following posedge+1.
   task automatic step(input logic [N-1:0] vld, input logic drdy_v);
      bit          open;
      int          w;
      logic [N-1:0] exp_rdy;
      beat_t       b;
      req_vld = vld;
      drdy    = drdy_v;
      #1;
      open = drdy_v || !m_vld;
      w    = -1;
      for (int j = 0; j < N; j++) begin
         int k;
         k = (m_ptr + j) % N;
         if (w < 0 && vld[k]) w = k;
      end
      exp_rdy = '0;
      if (open && w >= 0) exp_rdy[w] = 1'b1;
      check("req_rdy", 64'(req_rdy), 64'(exp_rdy));
      last_win = -1;
      if (open) begin
         if (w >= 0) begin
            b.idx = IDXW'(w);
            b.dat = dat_of(w);
            sb_q.push_back(b);
            m_vld    = 1'b1;
            m_dat    = dat_of(w);
            m_idx    = w;
            m_ptr    = (w + 1) % N;
            last_win = w;
         end else begin
            m_vld = 1'b0;
            m_dat = '0;
         end
      end
      @(posedge clk);
      #1;
      check("dvld", 64'(dvld), 64'(m_vld));
      check("ddat", 64'(ddat), 64'(m_dat));
      check("didx", 64'(didx), 64'(m_idx));
   endtask

   // Monitor: a beat is consumed when valid and ready meet at the next edge.
   always @(negedge clk) begin
      if (reset_n && dvld && drdy) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_beat", 64'(sb_q.size() != 0), 64'd1);
         end else begin
            beat_t e;
            e = sb_q.pop_front();
            check("sb_idx", 64'(didx), 64'(e.idx));
            check("sb_dat", 64'(ddat), 64'(e.dat));
         end
      end
   end

   initial begin
      int exp_seq[6];
      logic [N-1:0] pend;
      int           wcnt[N];

      exp_seq = '{0, 1, 2, 3, 0, 1};
      reset_n = 1'b0;
      req_vld = '0;
      drdy    = 1'b0;
      for (int k = 0; k < N; k++) req_dat[k*W +: W] = 32'hA5A5_0000 + 32'(k);
      m_ptr = 0; m_vld = 1'b0; m_dat = '0; m_idx = 0; last_win = -1;

      #12;
      check("rst_dvld", 64'(dvld), 64'd0);
      check("rst_ddat", 64'(ddat), 64'd0);
      check("rst_didx", 64'(didx), 64'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // S1: all valid, downstream always ready
      for (int i = 0; i < 6; i++) begin
         step(4'hF, 1'b1);
         check("s1_didx", 64'(didx), 64'(exp_seq[i]));
         check("s1_dvld", 64'(dvld), 64'd1);
      end

      // S2: requester 2 alone
      step(4'b0100, 1'b1);
      check("s2_ddat", 64'(ddat), 64'hA5A5_0002);
      check("s2_didx", 64'(didx), 64'd2);

      // S3: pointer now 3; hold the beat for 5 cycles, then release
      step(4'hF, 1'b1);
      check("s3_first", 64'(didx), 64'd3);
      for (int i = 0; i < 5; i++) begin
         step(4'hF, 1'b0);
         check("s3_rdy_held", 64'(req_rdy), 64'd0);
         check("s3_didx_held", 64'(didx), 64'd3);
         check("s3_ddat_held", 64'(ddat), 64'hA5A5_0003);
      end
      step(4'hF, 1'b1);
      check("s3_next", 64'(didx), 64'd0);

      // S4: no requester valid, zero-on-invalid
      step(4'h0, 1'b1);
      check("s4_dvld", 64'(dvld), 64'd0);
      check("s4_ddat", 64'(ddat), 64'd0);

      // S5: asynchronous reset mid-cycle with a beat held
      step(4'hF, 1'b0);
      check("s5_pre_dvld", 64'(dvld), 64'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("s5_rst_dvld", 64'(dvld), 64'd0);
      check("s5_rst_ddat", 64'(ddat), 64'd0);
      check("s5_rst_didx", 64'(didx), 64'd0);
      sb_q.delete();
      m_ptr = 0; m_vld = 1'b0; m_dat = '0; m_idx = 0;
      req_vld = '0;
      @(posedge clk);
      #3;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      step(4'hF, 1'b1);
      check("s5_first_win", 64'(didx), 64'd0);

      // S6: stress; requesters hold valid until granted
      pend = '0;
      for (int k = 0; k < N; k++) wcnt[k] = 0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         for (int k = 0; k < N; k++) begin
            if (!pend[k] && $urandom_range(0, 3) == 0) begin
               pend[k] = 1'b1;
               wcnt[k] = 0;
               req_dat[k*W +: W] = $urandom();
            end
         end
         step(pend, $urandom_range(0, 3) != 0);
         if (last_win >= 0) begin
            check("fair_wait", 64'(wcnt[last_win] < N), 64'd1);
            pend[last_win] = 1'b0;
            for (int k = 0; k < N; k++) begin
               if (k != last_win && pend[k]) wcnt[k]++;
            end
         end
      end

      // Drain and confirm no beat was lost
      for (int i = 0; i < 3; i++) step(4'h0, 1'b1);
      check("sb_empty", 64'(sb_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_prim_rr_arb

// File: doc/prim_rr_arb.md
PRIM_RR_ARB -- requirements
Module: prim_rr_arb

Interface
REQ-001 Parameters SHALL be, one per line:
  N, 4, number of requesters (2..16).
  WIDTH, 32, payload width in bits.
  ZERO_ON_INVALID, 0, when 1 the output data register loads zero on a cycle with no winner.
REQ-002 Ports SHALL be, one per line:
  clk  input  1  single clock; all state updates on the rising edge.
  reset_n  input  1  asynchronous reset, active low.
  req_vld_i  input  N  per-requester valid.
  req_rdy_o  output  N  per-requester ready; at most one bit high.
  req_dat_i  input  N*WIDTH  payloads; requester k occupies bits [k*WIDTH +: WIDTH].
  drdy_i  input  1  downstream ready.
  dvld_o  output  1  downstream valid.
  ddat_o  output  WIDTH  downstream payload, registered.
  didx_o  output  IDXW  index of the requester that supplied ddat_o, registered; IDXW = max(1, clog2(N)).

Function
REQ-003 The block SHALL share one registered valid/ready output stage among N requesters with round-robin fairness.
REQ-004 The output stage SHALL accept a new beat when open = drdy_i | !dvld_o.
REQ-005 The winner SHALL be the first index k with req_vld_i[k]=1, searching upward from ptr and wrapping from N-1 to 0.
REQ-006 req_rdy_o[k] SHALL be 1 only when open=1 and k is the winner; no requester SHALL see ready while the output is held.
REQ-007 A handshake on requester k (req_vld_i[k] & req_rdy_o[k]) SHALL load ddat_o with that requester's payload, load didx_o with k, and set dvld_o=1 on the next edge, giving 1-cycle latency.
REQ-008 When open=1 and no requester is valid, the next edge SHALL clear dvld_o.
  - didx_o SHALL hold its value.
  - ddat_o SHALL hold, or load zero when ZERO_ON_INVALID=1.
REQ-009 When open=0, dvld_o, ddat_o, didx_o and ptr SHALL hold their values.
REQ-010 ptr SHALL advance to (winner+1) mod N only on a requester handshake, so the winner becomes lowest priority.
REQ-011 A simultaneous downstream accept and upstream accept in the same cycle SHALL sustain one beat per cycle with no bubble.
REQ-012 The block SHALL impose no cap on the length of any requester's stall, provided drdy_i is eventually high; each valid requester SHALL be granted within N accepted beats.
REQ-013 A requester may drop req_vld_i before it is granted; the block SHALL NOT latch requests.
REQ-014 req_rdy_o SHALL be combinational from req_vld_i, ptr, drdy_i and dvld_o; all other outputs SHALL be registered.

Reset
REQ-015 While reset_n=0, the block SHALL asynchronously set dvld_o=0, ddat_o=0, didx_o=0 and ptr=0.
REQ-016 req_rdy_o SHALL evaluate to the winner one-hot after reset deassertion, because open=1 once dvld_o=0.
REQ-017 If reset asserts mid-transfer, the block SHALL drop the held beat; no beat is replayed after reset.
REQ-018 Reset deassertion SHALL be synchronised externally; the block SHALL contain no synchroniser.

Structure
REQ-019 Package prim_pkg SHALL hold the index-width function (IDXW computation), used by this block and its bench.
REQ-020 Sub-module prim_rr_pick SHALL be combinational.
  - Inputs: req, ptr.
  - Outputs: one-hot grant, encoded index, any.
  - Implementation: double-width masked priority search.
REQ-021 prim_rr_arb SHALL instantiate prim_rr_pick and contain only the output register, the pointer register and ready gating.

Verification
REQ-022 The bench SHALL cover the following directed scenarios (N=4, WIDTH=32):
  - All four requesters valid continuously, drdy_i=1 -> didx_o sequence 0,1,2,3,0,1 on consecutive cycles; dvld_o=1 every cycle from cycle 1.
  - Requester 2 only, with payload 0xA5A5_0002 -> ddat_o=0xA5A5_0002 and didx_o=2 one cycle after the handshake; ptr=3 afterwards.
  - drdy_i=0 for 5 cycles with a beat held and all requesters valid -> req_rdy_o=0000; ddat_o and didx_o stable; after drdy_i rises, the next winner is held index+1.
  - No requester valid with ZERO_ON_INVALID=1 and drdy_i=1 -> dvld_o=0 and ddat_o=0 next cycle.
  - reset_n pulsed low asynchronously mid-cycle while dvld_o=1 -> dvld_o, ddat_o and didx_o zero immediately; after release, requester 0 wins first.
  - Random valid/ready stress over 10k cycles -> scoreboard check of no lost or duplicated beat, and every requester granted within 4 accepted beats of asserting.
